// File: rtl/usrt_pkg.sv
// Shared types and constants for the USRT receiver.
package usrt_pkg;

  // Receiver frame states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    TAIL = 2'd2
  } usrt_state_e;

  localparam int unsigned USRT_DATA_W_DEF = 8;
  localparam int unsigned USRT_SYNC_DEPTH = 2;

endpackage

// File: rtl/usrt_sync.sv
// Two-flop synchronizer for one asynchronous input. With EDGE set, the output is
// a one-clk pulse on the rising edge of the synchronized signal; otherwise the
// output is the plain synchronized level.
module usrt_sync
  import usrt_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned Msb = USRT_SYNC_DEPTH - 1;

  logic [USRT_SYNC_DEPTH-1:0] sync_q;

  // Synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[USRT_SYNC_DEPTH-2:0], d};
  end

  if (EDGE) begin : g_edge
    logic prev_q;

    // Previous synchronized value for edge detection.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_q <= 1'b0;
      else      prev_q <= sync_q[Msb];
    end

    assign q = sync_q[Msb] & ~prev_q;
  end else begin : g_level
    assign q = sync_q[Msb];
  end

endmodule

// File: rtl/usrt_rx.sv
// Synchronous serial receiver clocked by an external bit clock.
// Define USRT_RX_PARITY_EN to expect one even-parity bit after the data bits.
module usrt_rx
  import usrt_pkg::*;
#(
  parameter int unsigned DATA_W = USRT_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usrt_clk,
  input  logic              cts,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              frm_err,
  output logic              par_err
);

`ifdef USRT_RX_PARITY_EN
  localparam int unsigned FrameLen = DATA_W + 1;
`else
  localparam int unsigned FrameLen = DATA_W;
`endif
  localparam int unsigned CntW = $clog2(DATA_W + 2);
  localparam logic [CntW-1:0] LastBit = CntW'(FrameLen - 1);

  logic bit_en, cts_s, rxd_s;

  usrt_sync #(.EDGE(1'b1)) u_clk_sync (.clk(clk), .rst(rst), .d(usrt_clk), .q(bit_en));
  usrt_sync #(.EDGE(1'b0)) u_cts_sync (.clk(clk), .rst(rst), .d(cts),      .q(cts_s));
  usrt_sync #(.EDGE(1'b0)) u_rxd_sync (.clk(clk), .rst(rst), .d(rxd),      .q(rxd_s));

  usrt_state_e                state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [FrameLen-1:0]        shift_q, shift_d, shift_next;
  logic [DATA_W-1:0]          data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       frm_err_q, frm_err_d;
  logic                       tail_err_q, tail_err_d;
  logic                       armed_q, armed_d;
  logic [USRT_SYNC_DEPTH-1:0] prime_q;
`ifdef USRT_RX_PARITY_EN
  logic                       par_err_q, par_err_d;
`endif

  assign shift_next = {rxd_s, shift_q[FrameLen-1:1]};

  // Next-state and output decode. armed blocks a frame already in progress at
  // reset release: cts_s reads 0 until the chain is primed, so that low is ignored.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    frm_err_d  = 1'b0;
    tail_err_d = tail_err_q;
    armed_d    = armed_q | (prime_q[USRT_SYNC_DEPTH-1] & ~cts_s);
`ifdef USRT_RX_PARITY_EN
    par_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cts_s && armed_q) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        // A cts fall outranks a coincident bit.
        if (!cts_s) begin
          state_d   = IDLE;
          frm_err_d = 1'b1;
        end else if (bit_en) begin
          shift_d = shift_next;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            state_d    = TAIL;
            data_d     = shift_next[DATA_W-1:0];
            valid_d    = 1'b1;
            tail_err_d = 1'b0;
`ifdef USRT_RX_PARITY_EN
            par_err_d  = ^shift_next;
`endif
          end
        end
      end
      TAIL: begin
        if (!cts_s) begin
          state_d = IDLE;
        end else if (bit_en && !tail_err_q) begin
          frm_err_d  = 1'b1;
          tail_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frm_err_q  <= 1'b0;
      tail_err_q <= 1'b0;
      armed_q    <= 1'b0;
      prime_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frm_err_q  <= frm_err_d;
      tail_err_q <= tail_err_d;
      armed_q    <= armed_d;
      prime_q    <= {prime_q[USRT_SYNC_DEPTH-2:0], 1'b1};
    end
  end

`ifdef USRT_RX_PARITY_EN
  // Parity error flag, aligned with valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_q <= 1'b0;
    else      par_err_q <= par_err_d;
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign data    = data_q;
  assign valid   = valid_q;
  assign frm_err = frm_err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/usrt_rx.md
USRT_RX -- requirements
Module: usrt_rx

Interface
REQ-001 Parameter DATA_W, default 8: number of data bits per frame (legal 2..16).
REQ-002 clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 usrt_clk  input  1  external USRT bit clock, asynchronous to clk; a bit is sampled on its rising edge.
REQ-005 cts  input  1  frame-active strobe from the far-end transmitter (its RTS); high for the whole frame.
REQ-006 rxd  input  1  serial data; LSB first; valid around the usrt_clk rising edge.
REQ-007 data  output  DATA_W  last received word; held until the next good frame.
REQ-008 valid  output  1  one-clk pulse: data has just been updated.
REQ-009 busy  output  1  high while the state is not IDLE.
REQ-010 frm_err  output  1  one-clk pulse on a short or over-long frame.
REQ-011 par_err  output  1  one-clk pulse on a parity mismatch (only with USRT_RX_PARITY_EN; otherwise tied 0).

Function
REQ-012 usrt_clk, cts and rxd shall each pass through a 2-flop synchronizer; bit_en shall be a one-clk pulse when synced usrt_clk is 1 and its previous value is 0.
REQ-013 rxd shall be sampled from its synchronized copy in the same clk cycle in which bit_en is high.
REQ-014 States: IDLE, RECV, TAIL. IDLE->RECV when synced cts is 1; RECV->TAIL when the last frame bit is sampled; TAIL->IDLE when synced cts is 0.
REQ-015 The shift register shall clear on entry to RECV; each bit_en in RECV shall shift rxd in at the MSB end (LSB-first framing), and the bit counter shall increment by 1.
REQ-016 The frame length is DATA_W bits, or DATA_W+1 bits with parity; the counter width shall be clog2(DATA_W+2).
REQ-017 On the last bit, data shall load and valid shall pulse in the clk cycle after that bit_en (latency 1 clk).
REQ-018 If synced cts falls in RECV before the last bit: frm_err shall pulse, data shall remain unchanged, and the state shall return to IDLE.
REQ-019 Any bit_en in TAIL while cts is still high shall pulse frm_err once per frame; data already delivered shall not be retracted.
REQ-020 bit_en and a cts fall in the same clk cycle in RECV: the cts fall wins, and the bit is discarded.
REQ-021 bit_en in IDLE shall be ignored.
REQ-022 busy shall be combinational from the state; valid, frm_err and par_err shall be registered.

Reset
REQ-023 With rst low: state=IDLE; data=0; valid=0; busy=0; frm_err=0; par_err=0; counter, shift register and synchronizers=0.
REQ-024 Reset asserted mid-frame shall discard the partial frame with no error pulse.
REQ-025 After reset release, a frame whose cts is already high shall not be received until cts has been seen low and then high again.

Configuration
REQ-026 Macro USRT_RX_PARITY_EN defined: one even-parity bit follows the data bits. On a mismatch, data still loads, valid pulses, and par_err pulses in the same cycle.
REQ-027 Macro USRT_RX_PARITY_EN undefined: frames are DATA_W bits, there is no parity logic, and par_err is constant 0.

Structure
REQ-028 Package usrt_pkg shall hold the state enum (IDLE/RECV/TAIL), USRT_DATA_W_DEF=8, and the synchronizer depth constant 2.
REQ-029 Sub-module usrt_sync shall implement the 2-flop synchronizer plus rising-edge pulse; it is instantiated for usrt_clk, and its plain synchronizer path is used for cts and rxd.

Verification
REQ-030 DATA_W=8, cts high, 8 usrt_clk edges carrying 0xA5 LSB first, then cts low -> data=0xA5, one valid pulse, frm_err=0.
REQ-031 cts dropped after 5 bits -> frm_err pulse, data keeps its previous value (0xA5), no valid pulse.
REQ-032 cts held high for 10 edges -> valid after edge 8 with the correct word, frm_err pulses exactly once, and the state returns to IDLE after cts falls.
REQ-033 USRT_RX_PARITY_EN, word 0x3C with parity 1 (bad) -> data=0x3C, valid and par_err pulse in the same cycle; with parity 0 -> par_err stays 0.
REQ-034 rst pulsed low after bit 4, with cts still high -> all outputs 0, no error pulse; the next full frame (cts low then high) is received correctly.
REQ-035 usrt_clk at 1/4 of the clk frequency with random phase -> every bit is sampled exactly once and back-to-back frames 0x00 and 0xFF are received correctly.
